// File: rtl/mips_pkg.sv
// Shared constants, fetch-state enum and address helper for the instruction fetch slice.
package mips_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned OP_MSB = 31;
   localparam int unsigned OP_LSB = 26;
   localparam int unsigned OP_W   = OP_MSB - OP_LSB + 1;

   localparam logic [XLEN-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

   typedef enum logic {
      StFetch,
      StHold
   } fetch_state_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load has priority over flush; otherwise contents are held.
module if_id_reg
   import mips_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            flush,
   input  logic [XLEN-1:0] instr_in,
   input  logic [XLEN-1:0] pc4_in,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc4,
   output logic            if_valid
);

   logic [XLEN-1:0] instr_d, instr_q;
   logic [XLEN-1:0] pc4_d, pc4_q;
   logic            valid_d, valid_q;

   // if_pc4 is only rewritten alongside a real instruction, never on a flush.
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (load) begin
         instr_d = instr_in;
         pc4_d   = pc4_in;
         valid_d = 1'b1;
      end else if (flush) begin
         instr_d = NOP_WORD;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= NOP_WORD;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign if_instr = instr_q;
   assign if_pc4   = pc4_q;
   assign if_valid = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch FSM, PC and pending buffer feeding the IF/ID register.
// Optional stall counter enabled by defining IFETCH_STALL_COUNTER_EN.
module instruction_fetch
   import mips_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc4,
   output logic            if_valid,
   output logic [OP_W-1:0] op,
   output logic [XLEN-1:0] stall_cycles
);

   fetch_state_e    state_d, state_q;
   logic [XLEN-1:0] pc_d, pc_q;
   logic [XLEN-1:0] pending_d, pending_q;
   logic [XLEN-1:0] pc4;
   logic            load, flush;
   logic [XLEN-1:0] load_instr;

   assign pc4 = pc_q + PC_STEP;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pending_d  = pending_q;
      load       = 1'b0;
      flush      = 1'b0;
      load_instr = imem_rdata;
      if (branch_taken) begin
         // Redirect wins over everything; any word acked this cycle is dropped.
         pc_d      = word_align(branch_target);
         pending_d = '0;
         flush     = 1'b1;
         state_d   = StFetch;
      end else begin
         unique case (state_q)
            StFetch: begin
               if (imem_ack && !stall) begin
                  load = 1'b1;
                  pc_d = pc4;
               end else if (imem_ack && stall) begin
                  pending_d = imem_rdata;
                  state_d   = StHold;
               end else if (!imem_ack && !stall) begin
                  flush = 1'b1;
               end
            end
            StHold: begin
               if (!stall) begin
                  load_instr = pending_q;
                  load       = 1'b1;
                  pc_d       = pc4;
                  state_d    = StFetch;
               end
            end
            default: state_d = StFetch;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StFetch;
         pc_q      <= word_align(RESET_PC);
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pending_q <= pending_d;
      end
   end

   assign imem_req  = (state_q == StFetch);
   assign imem_addr = word_align(pc_q);
   assign op        = if_instr[OP_MSB:OP_LSB];

   if_id_reg #(
      .NOP_WORD(NOP_WORD)
   ) u_if_id_reg (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .flush   (flush),
      .instr_in(load_instr),
      .pc4_in  (pc4),
      .if_instr(if_instr),
      .if_pc4  (if_pc4),
      .if_valid(if_valid)
   );

`ifdef IFETCH_STALL_COUNTER_EN
   logic [XLEN-1:0] stall_cnt_d, stall_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && if_valid && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; expected stall count follows IFETCH_STALL_COUNTER_EN.
module tb_instruction_fetch;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] if_instr;
   logic [31:0] if_pc4;
   logic        if_valid;
   logic [5:0]  op;
   logic [31:0] stall_cycles;

   int total;
   int bad;

`ifdef IFETCH_STALL_COUNTER_EN
   localparam logic [31:0] EXP_CNT = 32'd5;
`else
   localparam logic [31:0] EXP_CNT = 32'd0;
`endif

   instruction_fetch dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .if_instr     (if_instr),
      .if_pc4       (if_pc4),
      .if_valid     (if_valid),
      .op           (op),
      .stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      imem_ack = 1'b0; imem_rdata = '0;
      step(); step();
      reset = 1'b0;
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_req got %b want 1", imem_req); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got %h want 0", imem_addr); end
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", if_valid); end
      total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got %h want 0", if_instr); end
      total++; if (if_pc4 !== 32'h0) begin bad++; $display("FAIL rst_pc4 got %h want 0", if_pc4); end
      total++; if (stall_cycles !== 32'h0) begin bad++; $display("FAIL rst_cnt got %h want 0", stall_cycles); end
   endtask

   task automatic test_sequential();
      imem_ack = 1'b1; imem_rdata = 32'h8C01_0004;
      for (int i = 1; i <= 3; i++) begin
         step();
         total++; if (imem_addr !== 32'(4 * i)) begin bad++; $display("FAIL seq_addr%0d got %h want %h", i, imem_addr, 4 * i); end
         total++; if (if_pc4 !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc4%0d got %h want %h", i, if_pc4, 4 * i); end
         total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL seq_valid%0d got %b want 1", i, if_valid); end
         total++; if (op !== 6'b100011) begin bad++; $display("FAIL seq_op%0d got %b want 100011", i, op); end
      end
   endtask

   // Entered with pc=12, IF/ID = {8C010004, pc4=12}.
   task automatic test_stall_hold();
      stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h2000_0011;
      for (int i = 0; i < 3; i++) begin
         step();
         imem_rdata = 32'hDEAD_BEEF;
         total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_req%0d got %b want 0", i, imem_req); end
         total++; if (if_instr !== 32'h8C01_0004) begin bad++; $display("FAIL hold_instr%0d got %h want 8c010004", i, if_instr); end
         total++; if (if_pc4 !== 32'd12) begin bad++; $display("FAIL hold_pc4%0d got %h want c", i, if_pc4); end
      end
      stall = 1'b0;
      step();
      total++; if (if_instr !== 32'h2000_0011) begin bad++; $display("FAIL rel_instr got %h want 20000011", if_instr); end
      total++; if (if_pc4 !== 32'd16) begin bad++; $display("FAIL rel_pc4 got %h want 10", if_pc4); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'd16) begin bad++; $display("FAIL rel_addr got req=%b %h want req=1 10", imem_req, imem_addr); end
      imem_rdata = 32'h2400_0022;
      step();
      total++; if (if_instr !== 32'h2400_0022) begin bad++; $display("FAIL next_instr got %h want 24000022", if_instr); end
      total++; if (if_pc4 !== 32'd20) begin bad++; $display("FAIL next_pc4 got %h want 14", if_pc4); end
   endtask

   task automatic test_branch();
      branch_taken = 1'b1; branch_target = 32'h0000_0042; stall = 1'b1;
      imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
      step();
      branch_taken = 1'b0; stall = 1'b0; imem_rdata = 32'h2222_2222;
      total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL br_addr got %h want 40", imem_addr); end
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL br_valid got %b want 0", if_valid); end
      total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL br_instr got %h want 0", if_instr); end
      total++; if (if_pc4 !== 32'd20) begin bad++; $display("FAIL br_pc4 got %h want 14", if_pc4); end
      step();
      total++; if (if_instr !== 32'h2222_2222 || if_pc4 !== 32'h44) begin bad++; $display("FAIL br_next got %h/%h want 22222222/44", if_instr, if_pc4); end
      // Branch while parked in HOLD must discard the pending word.
      stall = 1'b1; imem_rdata = 32'h3333_3333;
      step();
      branch_taken = 1'b1; branch_target = 32'h0000_0100;
      step();
      branch_taken = 1'b0; stall = 1'b0; imem_ack = 1'b0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL brh_addr got req=%b %h want req=1 100", imem_req, imem_addr); end
      step();
      total++; if (if_valid !== 1'b0 || imem_addr !== 32'h100) begin bad++; $display("FAIL bubble got v=%b %h want v=0 100", if_valid, imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
      step();
      total++; if (if_instr !== 32'h4444_4444 || if_pc4 !== 32'h104) begin bad++; $display("FAIL brh_next got %h/%h want 44444444/104", if_instr, if_pc4); end
   endtask

   task automatic test_wrap();
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; imem_ack = 1'b0;
      step();
      branch_taken = 1'b0;
      total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pre got %h want fffffffc", imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h3C0A_0001;
      step();
      total++; if (if_pc4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got %h want 0", if_pc4); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got %h want 0", imem_addr); end
      total++; if (if_instr !== 32'h3C0A_0001) begin bad++; $display("FAIL wrap_instr got %h want 3c0a0001", if_instr); end
   endtask

   task automatic test_reset_in_hold();
      stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h5555_0000;
      step();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rh_hold got %b want 0", imem_req); end
      reset = 1'b1;
      step();
      reset = 1'b0; stall = 1'b0; imem_rdata = 32'hAAAA_0000;
      total++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin bad++; $display("FAIL rh_addr got req=%b %h want req=1 0", imem_req, imem_addr); end
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rh_valid got %b want 0", if_valid); end
      total++; if (stall_cycles !== 32'h0) begin bad++; $display("FAIL rh_cnt got %h want 0", stall_cycles); end
      step();
      total++; if (if_instr !== 32'hAAAA_0000 || if_pc4 !== 32'd4) begin bad++; $display("FAIL rh_next got %h/%h want aaaa0000/4", if_instr, if_pc4); end
   endtask

   task automatic test_stall_counter();
      reset = 1'b1; stall = 1'b0; imem_ack = 1'b0;
      step();
      reset = 1'b0; stall = 1'b1;
      step(); step();
      total++; if (stall_cycles !== 32'h0) begin bad++; $display("FAIL cnt_invalid got %h want 0", stall_cycles); end
      stall = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
      step();
      stall = 1'b1; imem_ack = 1'b0;
      for (int i = 0; i < 5; i++) step();
      total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL cnt_valid got %b want 1", if_valid); end
      total++; if (stall_cycles !== EXP_CNT) begin bad++; $display("FAIL cnt_value got %0d want %0d", stall_cycles, EXP_CNT); end
      stall = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_sequential();
      test_stall_hold();
      test_branch();
      test_wrap();
      test_reset_in_hold();
      test_stall_counter();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, instruction word driven while the IF/ID slot is empty.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 stall  input  1  downstream hazard; IF/ID contents SHALL be held.
REQ-006 branch_taken  input  1  redirect request from branch resolution.
REQ-007 branch_target  input  32  redirect address.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  32  word-aligned fetch address.
REQ-010 imem_ack  input  1  read data valid this cycle; meaningful only while imem_req=1.
REQ-011 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-012 if_instr  output  32  IF/ID instruction register.
REQ-013 if_pc4  output  32  IF/ID PC+4 register.
REQ-014 if_valid  output  1  IF/ID slot holds a real instruction.
REQ-015 op  output  6  if_instr[31:26], combinational; feeds the main decoder opcode input.
REQ-016 stall_cycles  output  32  stall counter (see Configuration).

Function
REQ-017 States: FETCH (imem_req=1, imem_addr=pc) and HOLD (imem_req=0, fetched word parked in pending buffer).
REQ-018 FETCH, imem_ack=1, stall=0: next edge if_instr<=imem_rdata, if_pc4<=pc+4, if_valid<=1, pc<=pc+4; remain FETCH (one instruction per cycle at zero-wait memory).
REQ-019 FETCH, imem_ack=1, stall=1: pending<=imem_rdata, pc unchanged, IF/ID held, go HOLD.
REQ-020 FETCH, imem_ack=0, stall=0: if_valid<=0, if_instr<=NOP_WORD (bubble); pc unchanged.
REQ-021 FETCH, imem_ack=0, stall=1: IF/ID and pc held.
REQ-022 HOLD, stall=1: all state held, imem_req=0.
REQ-023 HOLD, stall=0: if_instr<=pending, if_pc4<=pc+4, if_valid<=1, pc<=pc+4, go FETCH.
REQ-024 branch_taken=1 has priority over stall and imem_ack: pc<={branch_target[31:2],2'b00}, if_valid<=0, if_instr<=NOP_WORD, pending discarded, any same-cycle imem_ack data dropped, go FETCH.
REQ-025 PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 in pc and if_pc4.
REQ-026 imem_addr[1:0] SHALL always be 2'b00.
REQ-027 if_pc4 SHALL change only when if_valid is loaded to 1 or on reset.

Reset
REQ-028 On reset=1 at an edge: pc<=RESET_PC, state<=FETCH, if_instr<=NOP_WORD, if_pc4<=0, if_valid<=0, pending<=0, stall_cycles<=0; reset overrides branch_taken, stall, imem_ack.
REQ-029 Reset mid-HOLD or mid-request SHALL discard the pending word; first request after reset uses RESET_PC.

Configuration
REQ-030 Macro IFETCH_STALL_COUNTER_EN: when defined, stall_cycles increments by 1 each cycle with stall=1 and if_valid=1, saturating at 32'hFFFF_FFFF, cleared only by reset.
REQ-031 Without IFETCH_STALL_COUNTER_EN, stall_cycles port SHALL exist and be tied to 0; no counter logic synthesised.

Structure
REQ-032 Shared package mips_pkg SHALL hold NOP_WORD default, opcode field bounds (31:26), instruction/address width constant (32) and the fetch state enum.
REQ-033 Sub-module if_id_reg SHALL implement the IF/ID register (load, hold, flush inputs); FSM and PC stay in instruction_fetch.

Verification
REQ-034 Reset, RESET_PC=0, imem_ack=1 every cycle, rdata=0x8C01_0004 -> imem_addr 0,4,8; if_valid=1 from cycle 2; op=6'b100011; if_pc4=4,8,12.
REQ-035 stall=1 for 3 cycles while imem_ack=1 -> state HOLD, imem_req=0, if_instr/if_pc4 unchanged; after release pending word appears next cycle, no instruction lost or duplicated.
REQ-036 branch_taken=1, target=0x0000_0042, simultaneous stall=1 and imem_ack=1 -> next imem_addr=0x0000_0040, if_valid=0, if_instr=NOP_WORD, acked word dropped.
REQ-037 pc=0xFFFF_FFFC, ack -> if_pc4=0x0000_0000, next imem_addr=0x0000_0000.
REQ-038 reset asserted in HOLD -> next cycle imem_addr=RESET_PC, if_valid=0, pending cleared, stall_cycles=0.
REQ-039 With IFETCH_STALL_COUNTER_EN, 5 stalled cycles with if_valid=1 plus 2 stalled with if_valid=0 -> stall_cycles=5; without macro -> 0.
